// File: rtl/vram_write_arbiter.sv
// Two-requester arbiter for the byte-wide VRAM write port: serialises the 16-bit address
// high byte first, then pulses the write enable. Define VRAM_ARB_ROUND_ROBIN_EN for round-robin ties.
module vram_write_arbiter #(
  parameter logic [15:0] VRAM_START_ADDRESS = 16'hE8A5,
  parameter logic [15:0] VRAM_SIZE          = 16'h175B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] addr0,
  input  logic [7:0]  data0,
  output logic        ack0,
  output logic        err0,
  input  logic        req1,
  input  logic [15:0] addr1,
  input  logic [7:0]  data1,
  output logic        ack1,
  output logic        err1,
  output logic        vram_wr_en,
  output logic [7:0]  vram_wr_addr,
  output logic [7:0]  vram_wr_data,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, WRITE, REJECT} state_t;

  // 17-bit end so a window reaching the top of the address space includes 16'hFFFF
  localparam logic [16:0] VRAM_END = {1'b0, VRAM_START_ADDRESS} + {1'b0, VRAM_SIZE};

  state_t      state, state_nx;
  logic [15:0] addr_q, addr_nx;
  logic [7:0]  data_q, data_nx;
  logic        gnt_q, gnt_nx;
  logic        pick_valid, pick_id;
  logic [15:0] pick_addr;
  logic        pick_ok;

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  logic last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else if (pick_valid) last_q <= pick_id;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      gnt_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      addr_q <= addr_nx;
      data_q <= data_nx;
      gnt_q  <= gnt_nx;
    end
  end

  // In WRITE only the requester not being acked may be granted
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = 1'b0;
    case (state)
      IDLE: begin
        pick_valid = req0 | req1;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
        pick_id = (req0 & req1) ? ~last_q : req1;
`else
        pick_id = req1 & ~req0;
`endif
      end
      WRITE: begin
        pick_valid = gnt_q ? req0 : req1;
        pick_id    = ~gnt_q;
      end
      default: ;
    endcase
    pick_addr = pick_id ? addr1 : addr0;
    pick_ok   = (pick_addr >= VRAM_START_ADDRESS) && ({1'b0, pick_addr} < VRAM_END);
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr_q;
    data_nx      = data_q;
    gnt_nx       = gnt_q;
    vram_wr_en   = 1'b0;
    vram_wr_addr = '0;
    vram_wr_data = '0;
    ack0         = 1'b0;
    err0         = 1'b0;
    ack1         = 1'b0;
    err1         = 1'b0;
    busy         = (state != IDLE);

    case (state)
      ADDR_HI: begin
        vram_wr_addr = addr_q[15:8];
        state_nx     = ADDR_LO;
      end
      ADDR_LO: begin
        vram_wr_addr = addr_q[7:0];
        state_nx     = WRITE;
      end
      WRITE: begin
        vram_wr_en   = 1'b1;
        vram_wr_data = data_q;
        ack0         = ~gnt_q;
        ack1         = gnt_q;
        state_nx     = IDLE;
      end
      REJECT: begin
        ack0     = ~gnt_q;
        err0     = ~gnt_q;
        ack1     = gnt_q;
        err1     = gnt_q;
        state_nx = IDLE;
      end
      default: ;
    endcase

    if (pick_valid) begin
      addr_nx  = pick_addr;
      data_nx  = pick_id ? data1 : data0;
      gnt_nx   = pick_id;
      state_nx = pick_ok ? ADDR_HI : REJECT;
    end
  end

endmodule
